e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  Multiply/divide unit for the E stage. Sits beside the E-stage ALU and takes
//  the same forwarded operands (Src_A/Src_B). Its MDUOut is muxed against
//  ALUOut into the E/M pipeline register.
//  Owns the HI/LO registers. Runs mult/multu/div/divu as fixed-latency
//  multi-cycle ops, and serves mfhi/mflo/mthi/mtlo.
//  Busy and Start drive the hazard unit's stall of MDU-class instructions.
// PARAMETERS
//  MULT_CYCLES  5   cycles Busy stays high for mult/multu (>=1)
//  DIV_CYCLES   10  cycles Busy stays high for div/divu (>=1)
// PORTS
//  clk      in   1   rising-edge clock
//  reset    in   1   asynchronous, active-high reset
//  Src_A    in   32  operand rs (forwarded)
//  Src_B    in   32  operand rt (forwarded)
//  MDUOp    in   4   0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu,
//                    0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo; others = none
//  Start    in   1   one-cycle pulse issuing mult/multu/div/divu
//  Busy     out  1   operation in progress
//  HI       out  32  HI register
//  LO       out  32  LO register
//  MDUOut   out  32  mfhi -> HI, mflo -> LO, otherwise 32'h0 (combinational)
// BEHAVIOUR
//  Reset (async, any time, including mid-operation):
//   - HI=0, LO=0, Busy=0, counter=0.
//   - Any pending result is discarded.
//  FSM states:
//   - IDLE -> MUL on Start & MDUOp in {mult,multu} & !Busy; load counter=MULT_CYCLES.
//   - IDLE -> DIV on Start & MDUOp in {div,divu} & !Busy; load counter=DIV_CYCLES.
//   - MUL/DIV: counter decrements each edge. At counter==1 the edge writes HI/LO
//     and returns to IDLE.
//  Latency and Busy timing:
//   - Operands and op type are latched at the Start edge. Later changes to Src_A/B
//     do not affect the result.
//   - Busy=1 for exactly N cycles after the Start edge (N = MULT_CYCLES or
//     DIV_CYCLES). It falls on the same edge that updates HI/LO.
//   - HI/LO hold their old values until that edge. The result may be computed
//     combinationally from the latched operands; an iterative datapath is
//     allowed if it meets N.
//  Arithmetic:
//   - mult: {HI,LO} = signed 64-bit product. multu: same, unsigned.
//   - div: LO = quotient truncated toward zero; HI = remainder with the sign of
//     the dividend.
//   - divu: unsigned LO = quotient, HI = remainder.
//   - 32'h80000000 div 32'hFFFFFFFF: LO=32'h80000000, HI=0 (wraps, no trap).
//   - Divisor 0 (div or divu): runs the full DIV_CYCLES with Busy, then leaves
//     HI/LO unchanged.
//  mthi/mtlo:
//   - Write Src_A into HI/LO at the edge when MDUOp selects them and Busy=0.
//   - Start is not needed for these ops.
//  Illegal issues (all ignored; no state change, no error):
//   - Start or mthi/mtlo while Busy=1 (the hazard unit prevents this).
//   - Start with a non-mult/div MDUOp.
//  Reads while busy: mfhi/mflo during Busy return the old HI/LO. The stall
//   logic is responsible for blocking these reads.
// TESTING
//  - mult Src_A=-5 (FFFFFFFB), Src_B=3 -> Busy high exactly 5 cycles, then
//    HI=FFFFFFFF, LO=FFFFFFF1.
//  - multu FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE, LO=00000001. Change Src_A/B during
//    Busy -> result unaffected.
//  - div -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF after 10 cycles. divu 7/2 -> LO=3, HI=1.
//    80000000 div FFFFFFFF -> LO=80000000, HI=0.
//  - mthi 1234, mtlo 5678, then div x/0 -> Busy 10 cycles, HI=1234, LO=5678.
//    mfhi drives MDUOut=1234.
//  - mult issued, then mthi AAAA in cycle 2 of Busy -> mthi ignored; HI/LO take
//    the product.
//  - Assert reset in cycle 3 of a div -> Busy=0, HI=LO=0 immediately. A new mult
//    after reset completes normally.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit.
//   Owns the HI/LO registers. Runs mult/multu/div/divu as fixed-latency
//   multi-cycle operations and serves mfhi/mflo/mthi/mtlo.
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous, active-high reset
//   Src_A   - operand rs (forwarded)
//   Src_B   - operand rt (forwarded)
//   MDUOp   - operation select (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//             5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none)
//   Start   - one-cycle pulse issuing mult/multu/div/divu
//   Busy    - high while a multi-cycle operation is in progress
//   HI, LO  - architectural HI/LO registers
//   MDUOut  - HI for mfhi, LO for mflo, zero otherwise (combinational)
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Src_A,
  input  logic [31:0] Src_B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          signed_q, signed_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  // Datapath works purely from latched operands, so forwarded inputs may
  // change freely while the operation is in flight.
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, divisor, quo_u, rem_u, quo, rem;

  always_comb begin
    if (signed_q)
      prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    else
      prod = {32'b0, a_q} * {32'b0, b_q};

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 wraps back naturally.
    mag_a   = (signed_q && a_q[31]) ? (32'd0 - a_q) : a_q;
    mag_b   = (signed_q && b_q[31]) ? (32'd0 - b_q) : b_q;
    // Keep the divider defined for a zero divisor; its result is discarded.
    divisor = (b_q == 32'd0) ? 32'd1 : mag_b;
    quo_u   = mag_a / divisor;
    rem_u   = mag_a % divisor;
    quo     = (signed_q && (a_q[31] ^ b_q[31])) ? (32'd0 - quo_u) : quo_u;
    rem     = (signed_q && a_q[31]) ? (32'd0 - rem_u) : rem_u;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start && (MDUOp == OP_MULT || MDUOp == OP_MULTU)) begin
          state_d  = S_MUL;
          cnt_d    = CW'(MULT_CYCLES);
          a_d      = Src_A;
          b_d      = Src_B;
          signed_d = (MDUOp == OP_MULT);
        end else if (Start && (MDUOp == OP_DIV || MDUOp == OP_DIVU)) begin
          state_d  = S_DIV;
          cnt_d    = CW'(DIV_CYCLES);
          a_d      = Src_A;
          b_d      = Src_B;
          signed_d = (MDUOp == OP_DIV);
        end
        // Moves to HI/LO only land while idle; no Start needed.
        if (MDUOp == OP_MTHI) hi_d = Src_A;
        if (MDUOp == OP_MTLO) lo_d = Src_A;
      end
      S_MUL: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
        end
      end
      S_DIV: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign Busy = (state_q != S_IDLE);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    MDUOut = 32'h0;
    if (MDUOp == OP_MFHI)      MDUOut = hi_q;
    else if (MDUOp == OP_MFLO) MDUOut = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Src_A, Src_B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO, MDUOut;

  int total = 0;
  int bad   = 0;

  // Reference HI/LO tracked by the bench.
  logic [31:0] m_hi, m_lo;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Src_A(Src_A), .Src_B(Src_B),
    .MDUOp(MDUOp), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO),
    .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
    string       name;
  } vec_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else
      $display("ok   %s: %08h", name, act);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else
      $display("ok   %s: %0d", name, act);
  endtask

  // Architectural rules, computed with wide integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      OP_MULTU: begin p = 64'(ua * ub); hi = p[63:32]; lo = p[31:0]; end
      OP_DIV: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        lo = q[31:0]; hi = r[31:0];
      end
      OP_DIVU: if (b != 0) begin
        q = ua / ub; r = ua % ub;
        lo = q[31:0]; hi = r[31:0];
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multi-cycle op, scramble the operands during Busy, measure how long
  // Busy stays up and confirm HI/LO hold until completion.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_cycles, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input string name);
    int cyc;
    logic [31:0] old_hi, old_lo;
    logic held;
    old_hi = HI; old_lo = LO; held = 1'b1;
    MDUOp = op; Src_A = a; Src_B = b; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = OP_NONE;
    cyc = 0;
    while (Busy && cyc < 100) begin
      Src_A = $urandom; Src_B = $urandom;
      if (HI !== old_hi || LO !== old_lo) held = 1'b0;
      cyc++;
      tick();
    end
    check_int({name, " busy_cycles"}, cyc, exp_cycles);
    check_int({name, " hilo_held"}, int'(held), 1);
    check32({name, " HI"}, HI, exp_hi);
    check32({name, " LO"}, LO, exp_lo);
  endtask

  task automatic move(input logic [3:0] op, input logic [31:0] v);
    MDUOp = op; Src_A = v;
    tick();
    MDUOp = OP_NONE;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{OP_MULT,  32'hFFFFFFFB, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFF1, MC, "mult_-5x3"};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC, "multu_max"};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC, "div_-7/2"};
    vecs[3] = '{OP_DIVU,  32'h7,        32'h2,        32'h00000001, 32'h00000003, DC, "divu_7/2"};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC, "div_ovf"};

    reset = 1'b1; Start = 1'b0; MDUOp = OP_NONE; Src_A = '0; Src_B = '0;
    tick(); tick();
    check_int("reset Busy", int'(Busy), 0);
    check32("reset HI", HI, 32'h0);
    check32("reset LO", LO, 32'h0);
    reset = 1'b0;
    tick();

    // Directed vectors
    for (int i = 0; i < 5; i++)
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cycles,
            vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].name);

    // mthi/mtlo then divide by zero leaves HI/LO alone
    move(OP_MTHI, 32'h1234);
    move(OP_MTLO, 32'h5678);
    issue(OP_DIV, 32'h55, 32'h0, DC, 32'h1234, 32'h5678, "div_by0");
    issue(OP_DIVU, 32'h55, 32'h0, DC, 32'h1234, 32'h5678, "divu_by0");
    MDUOp = OP_MFHI; #1;
    check32("mfhi MDUOut", MDUOut, 32'h1234);
    MDUOp = OP_MFLO; #1;
    check32("mflo MDUOut", MDUOut, 32'h5678);
    MDUOp = 4'hF; #1;
    check32("other MDUOut", MDUOut, 32'h0);
    MDUOp = OP_NONE;

    // Start with a non-arithmetic op is ignored
    MDUOp = OP_MFLO; Start = 1'b1; tick();
    Start = 1'b0; MDUOp = OP_NONE;
    check_int("start_mflo Busy", int'(Busy), 0);

    // mthi, mtlo and a second Start during Busy are ignored; mfhi reads old HI
    begin
      int cyc;
      MDUOp = OP_MULT; Src_A = 32'd7; Src_B = 32'hFFFFFFFE; Start = 1'b1;
      tick();                                   // Busy cycle 1
      Start = 1'b0; MDUOp = OP_NONE;
      tick();                                   // Busy cycle 2
      MDUOp = OP_MFHI; #1;
      check32("busy mfhi old", MDUOut, 32'h1234);
      MDUOp = OP_MTHI; Src_A = 32'hAAAA; tick();
      MDUOp = OP_MTLO; Src_A = 32'hBBBB; tick();
      MDUOp = OP_DIVU; Src_A = 32'h9; Src_B = 32'h2; Start = 1'b1; tick();
      Start = 1'b0; MDUOp = OP_NONE;
      cyc = 4;                                  // four Busy cycles elapsed
      while (Busy && cyc < 100) begin cyc++; tick(); end
      check_int("mthi_busy cycles", cyc, MC);
      check32("mthi_busy HI", HI, 32'hFFFFFFFF);
      check32("mthi_busy LO", LO, 32'hFFFFFFF2);
      tick();
      check_int("mthi_busy no restart", int'(Busy), 0);
    end

    // Async reset in cycle 3 of a divide
    MDUOp = OP_DIVU; Src_A = 32'd100; Src_B = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = OP_NONE;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    check_int("mid_reset Busy", int'(Busy), 0);
    check32("mid_reset HI", HI, 32'h0);
    check32("mid_reset LO", LO, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    issue(OP_MULTU, 32'h10000, 32'h10001, MC, 32'h1, 32'h10000, "post_reset_multu");

    // Randomized ops against the reference model
    m_hi = HI; m_lo = LO;
    m_hi = 32'h1;  m_lo = 32'h10000;
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      b  = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      case (op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          model(op, a, b, m_hi, m_lo);
          issue(op, a, b, (op == OP_MULT || op == OP_MULTU) ? MC : DC,
                m_hi, m_lo, $sformatf("rnd%0d op%0d", i, op));
        end
        OP_MTHI: begin move(op, a); m_hi = a; check32($sformatf("rnd%0d mthi", i), HI, m_hi); end
        OP_MTLO: begin move(op, a); m_lo = a; check32($sformatf("rnd%0d mtlo", i), LO, m_lo); end
        OP_MFHI: begin MDUOp = op; #1; check32($sformatf("rnd%0d mfhi", i), MDUOut, m_hi); MDUOp = OP_NONE; tick(); end
        default: begin MDUOp = op; #1; check32($sformatf("rnd%0d mflo", i), MDUOut, m_lo); MDUOp = OP_NONE; tick(); end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
